ecg_window_92: RTL and testbench
================================

ECG_WINDOW_92 -- requirements
Module: ecg_window_92

Interface
REQ-001 Parameter BITSIZE, default 16: width of one signed Q4.11 sample (2048 = 1.0).
REQ-002 Parameter WIN_SIZE, default 92: samples per output window, matching the encoder input width.
REQ-003 Parameter HOP, default 46: new samples between successive windows; legal range 1..WIN_SIZE.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset: 0 = reset asserted, 1 = run.
REQ-006 s_data  input  BITSIZE  signed Q4.11 ECG sample.
REQ-007 s_valid  input  1  s_data is valid this cycle.
REQ-008 s_ready  output  1  block can accept a sample this cycle.
REQ-009 flush  input  1  synchronous clear of window contents and counters.
REQ-010 x  output  BITSIZE*WIN_SIZE  packed window; x[i*BITSIZE +: BITSIZE] = sample i, where i=0 is oldest.
REQ-011 x_valid  output  1  x holds a complete window.
REQ-012 x_ready  input  1  consumer has taken the window, typically driven by the encoder done pulse.
REQ-013 win_cnt  output  16  number of windows emitted since reset, wrapping at 65535 -> 0.

Function
REQ-014 The block SHALL run a 2-state FSM: FILL (s_ready=1, x_valid=0) and HOLD (s_ready=0, x_valid=1).
REQ-015 An accepted sample (s_valid & s_ready) SHALL shift the buffer down one slot: slot i takes slot i+1, and the new sample enters slot WIN_SIZE-1.
REQ-016 fill_cnt (7 bits) SHALL increment on each accepted sample in FILL.
REQ-017 When the accepted sample brings fill_cnt to WIN_SIZE, the FSM SHALL enter HOLD and assert x_valid on the next cycle; latency from the final sample handshake to x_valid is 1 cycle.
REQ-018 In HOLD, x SHALL remain bit-stable and s_data/s_valid SHALL be ignored.
REQ-019 On x_valid & x_ready, the FSM SHALL return to FILL, set fill_cnt = WIN_SIZE-HOP, keep the buffer contents, and increment win_cnt.
REQ-020 The next window therefore requires exactly HOP new samples; HOP = WIN_SIZE gives non-overlapping windows.
REQ-021 x_ready while x_valid=0 SHALL have no effect.
REQ-022 flush=1 SHALL take priority over every other event:
  - buffer cleared to 0, fill_cnt cleared to 0, FSM to FILL;
  - win_cnt unchanged;
  - any sample or x_ready in the same cycle discarded.
REQ-023 The first window after reset or flush SHALL require WIN_SIZE samples.
REQ-024 s_ready SHALL be a registered function of FSM state only, with no combinational path from s_valid.

Reset
REQ-025 While reset=0, outputs SHALL be: x=0, x_valid=0, s_ready=0, win_cnt=0; FSM=FILL, fill_cnt=0.
REQ-026 s_ready SHALL go to 1 on the first clock edge after reset deasserts.
REQ-027 Reset asserted mid-fill or during HOLD SHALL discard the partial or pending window immediately, asynchronously.

Configuration
REQ-028 Macro ECG_WIN_CLIP_EN: when defined, each accepted sample SHALL be saturated to [-4096, 4095] (±2.0) before it enters the buffer.
REQ-029 When ECG_WIN_CLIP_EN is undefined, samples SHALL be stored unmodified and no clipping logic SHALL be present.

Verification
REQ-030 Reset, then 92 consecutive samples of value k (k = 0..91):
  - x_valid=1 exactly 1 cycle after the 92nd handshake;
  - slot i = i;
  - s_ready=0.
REQ-031 Hold x_ready=0 for 50 cycles while s_valid=1 with data 999:
  - x stays unchanged;
  - no 999 appears in the buffer.
REQ-032 Pulse x_ready, then feed 46 samples of value 100+j:
  - second window has slots 0..45 = 46..91 and slots 46..91 = 100..145;
  - win_cnt = 2 after the second ack.
REQ-033 Assert flush after 30 samples:
  - x = 0, fill_cnt = 0;
  - a full 92 samples are then needed before x_valid.
REQ-034 Assert reset=0 during HOLD:
  - x_valid = 0 and x = 0 immediately, with no clock edge needed.
REQ-035 With ECG_WIN_CLIP_EN defined, feed samples 8000 and -8000:
  - stored as 4095 and -4096.
  - With the macro undefined, the same samples are stored as 8000 and -8000.

Source files
------------

// File: rtl/ecg_window_92.sv
// ecg_window_92: sliding sample window feeding the ECG encoder.
// Incoming Q4.11 samples shift into a WIN_SIZE-deep buffer. Once the buffer
// is full, the window is presented on x/x_valid and held until the consumer
// acknowledges it. After each acknowledge, only HOP new samples are needed
// before the next window is presented.
// Optional build macro: ECG_WIN_CLIP_EN saturates each accepted sample to
// [-4096, 4095] before it is stored.
module ecg_window_92 #(
    parameter int BITSIZE  = 16,
    parameter int WIN_SIZE = 92,
    parameter int HOP      = 46
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [BITSIZE-1:0]   s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        flush,
    output logic [BITSIZE*WIN_SIZE-1:0] x,
    output logic                        x_valid,
    input  logic                        x_ready,
    output logic [15:0]                 win_cnt
);

    localparam int XW = BITSIZE * WIN_SIZE;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [6:0]                fill_cnt_q, fill_cnt_d;
    logic [15:0]               win_cnt_q, win_cnt_d;
    logic                      s_ready_q, s_ready_d;
    logic [XW-1:0]             buf_q, buf_d;
    logic signed [BITSIZE-1:0] sample_in;
    logic                      accept;
    logic                      ack;
    logic                      last_sample;

`ifdef ECG_WIN_CLIP_EN
    localparam logic signed [BITSIZE-1:0] CLIP_HI = BITSIZE'(4095);
    localparam logic signed [BITSIZE-1:0] CLIP_LO = BITSIZE'(-4096);

    // Saturate the incoming sample to +/-2.0 before it enters the buffer
    always_comb begin
        sample_in = s_data;
        if (s_data > CLIP_HI) begin
            sample_in = CLIP_HI;
        end else if (s_data < CLIP_LO) begin
            sample_in = CLIP_LO;
        end
    end
`else
    assign sample_in = s_data;
`endif

    assign accept      = s_valid & s_ready_q & (state_q == FILL);
    assign ack         = (state_q == HOLD) & x_ready;
    assign last_sample = (fill_cnt_q == 7'(WIN_SIZE - 1));

    // State register; reset discards any partial or pending window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush wins, otherwise fill until full, then hold until acked
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (accept && last_sample) state_d = HOLD;
                HOLD:    if (x_ready)               state_d = FILL;
                default:                            state_d = FILL;
            endcase
        end
    end

    // Output logic: s_ready is registered from the upcoming state, x_valid follows HOLD
    always_comb begin
        s_ready_d = (state_d == FILL);
        x_valid   = (state_q == HOLD);
    end

    // Datapath next values: shift on accept, rewind fill count on acknowledge
    always_comb begin
        buf_d      = buf_q;
        fill_cnt_d = fill_cnt_q;
        win_cnt_d  = win_cnt_q;
        if (flush) begin
            buf_d      = '0;
            fill_cnt_d = '0;
        end else if (accept) begin
            buf_d      = {sample_in, buf_q[XW-1:BITSIZE]};
            fill_cnt_d = fill_cnt_q + 7'd1;
        end else if (ack) begin
            fill_cnt_d = 7'(WIN_SIZE - HOP);
            win_cnt_d  = win_cnt_q + 16'd1;
        end
    end

    // Datapath registers; s_ready stays low while in reset and rises on the first edge after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q      <= '0;
            fill_cnt_q <= '0;
            win_cnt_q  <= '0;
            s_ready_q  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            fill_cnt_q <= fill_cnt_d;
            win_cnt_q  <= win_cnt_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign x       = buf_q;
    assign s_ready = s_ready_q;
    assign win_cnt = win_cnt_q;

endmodule

// File: tb/tb_ecg_window_92.sv
// tb_ecg_window_92: directed, table-driven bench for ecg_window_92.
module tb_ecg_window_92;

    localparam int BITSIZE  = 16;
    localparam int WIN_SIZE = 92;
    localparam int HOP      = 46;
    localparam int XW       = BITSIZE * WIN_SIZE;

    logic                      clk = 1'b0;
    logic                      reset;
    logic signed [BITSIZE-1:0] sData;
    logic                      sValid;
    logic                      sReady;
    logic                      flush;
    logic [XW-1:0]             x;
    logic                      xValid;
    logic                      xReady;
    logic [15:0]               winCnt;

    int checksRun    = 0;
    int checksPassed = 0;

    typedef struct {
        string name;
        int    count;
        logic  sv;
        int    dataBase;
        logic  xr;
        logic  fl;
        logic  expXValid;
        logic  expSReady;
        int    expWinCnt;
        int    windowSel;
    } phase_t;

    phase_t        phases[13];
    logic [XW-1:0] expWin[4];

    // Free-running clock, period 10
    always #5 clk = ~clk;

    ecg_window_92 #(
        .BITSIZE (BITSIZE),
        .WIN_SIZE(WIN_SIZE),
        .HOP     (HOP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s_data (sData),
        .s_valid(sValid),
        .s_ready(sReady),
        .flush  (flush),
        .x      (x),
        .x_valid(xValid),
        .x_ready(xReady),
        .win_cnt(winCnt)
    );

    // Scalar comparison with FAIL reporting
    task automatic checkOutput(input string name, input int act, input int exp);
        checksRun++;
        if (act == exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Whole-window comparison; reports the first differing slot
    task automatic checkWindow(input string name, input logic [XW-1:0] exp);
        int badSlot;
        checksRun++;
        if (x === exp) begin
            checksPassed++;
        end else begin
            badSlot = -1;
            for (int i = WIN_SIZE - 1; i >= 0; i--) begin
                if (x[i*BITSIZE +: BITSIZE] !== exp[i*BITSIZE +: BITSIZE]) badSlot = i;
            end
            $display("[TB] FAIL %s: slot %0d got %0d, expected %0d", name, badSlot,
                     $signed(x[badSlot*BITSIZE +: BITSIZE]),
                     $signed(exp[badSlot*BITSIZE +: BITSIZE]));
        end
    endtask

    // Return inputs to idle
    task automatic idleInputs();
        sValid = 1'b0;
        sData  = '0;
        xReady = 1'b0;
        flush  = 1'b0;
    endtask

    // Drive one phase of the table, then check outputs after its last edge
    task automatic applyStimulus(input phase_t p);
        for (int j = 0; j < p.count; j++) begin
            @(negedge clk);
            sValid = p.sv;
            sData  = BITSIZE'(p.dataBase + j);
            xReady = p.xr;
            flush  = p.fl;
        end
        @(negedge clk);
        idleInputs();
        checkOutput({p.name, " x_valid"}, int'(xValid), int'(p.expXValid));
        checkOutput({p.name, " s_ready"}, int'(sReady), int'(p.expSReady));
        checkOutput({p.name, " win_cnt"}, int'(winCnt), p.expWinCnt);
        if (p.windowSel >= 0) begin
            checkWindow({p.name, " window"}, expWin[p.windowSel]);
        end
    endtask

    // Feed one sample in a single cycle
    task automatic feedSample(input int value);
        @(negedge clk);
        sValid = 1'b1;
        sData  = BITSIZE'(value);
    endtask

    // Main sequence
    initial begin
        int clipHi;
        int clipLo;

        // Expected windows from hand formulas
        expWin[0] = '0;
        for (int i = 0; i < WIN_SIZE; i++) begin
            expWin[1][i*BITSIZE +: BITSIZE] = BITSIZE'(i);
            expWin[2][i*BITSIZE +: BITSIZE] = (i < WIN_SIZE - HOP) ? BITSIZE'(i + HOP)
                                                                   : BITSIZE'(100 + i - (WIN_SIZE - HOP));
            expWin[3][i*BITSIZE +: BITSIZE] = BITSIZE'(600 + i);
        end

        //            name         cnt sv  base  xr    fl    xv    sr    wc win
        phases[0]  = '{"fill91",    91, 1'b1, 0,   1'b0, 1'b0, 1'b0, 1'b1, 0, -1};
        phases[1]  = '{"fill92",    1,  1'b1, 91,  1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        phases[2]  = '{"hold50",    50, 1'b1, 999, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        phases[3]  = '{"ack1",      1,  1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b1, 1, 1};
        phases[4]  = '{"hop45",     45, 1'b1, 100, 1'b0, 1'b0, 1'b0, 1'b1, 1, -1};
        phases[5]  = '{"hop46",     1,  1'b1, 145, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2};
        phases[6]  = '{"ack2",      1,  1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b1, 2, 2};
        phases[7]  = '{"xrIdle",    3,  1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b1, 2, 2};
        phases[8]  = '{"fill30",    30, 1'b1, 500, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1};
        phases[9]  = '{"flush",     1,  1'b1, 7,   1'b1, 1'b1, 1'b0, 1'b1, 2, 0};
        phases[10] = '{"refill91",  91, 1'b1, 600, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1};
        phases[11] = '{"refill92",  1,  1'b1, 691, 1'b0, 1'b0, 1'b1, 1'b0, 2, 3};
        phases[12] = '{"flushHold", 1,  1'b0, 0,   1'b1, 1'b1, 1'b0, 1'b1, 2, 0};

        // Reset state before any clock edge
        reset = 1'b0;
        idleInputs();
        #2;
        checkOutput("rst x_valid", int'(xValid), 0);
        checkOutput("rst s_ready", int'(sReady), 0);
        checkOutput("rst win_cnt", int'(winCnt), 0);
        checkWindow("rst x", expWin[0]);

        // Samples offered during reset are not accepted
        sValid = 1'b1;
        sData  = 16'sd55;
        repeat (3) @(negedge clk);
        checkOutput("rst held s_ready", int'(sReady), 0);
        checkWindow("rst held x", expWin[0]);

        // Release reset; s_ready rises on the first edge afterwards
        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post-rst s_ready", int'(sReady), 1);
        checkOutput("post-rst x_valid", int'(xValid), 0);

        for (int p = 0; p < 13; p++) begin
            applyStimulus(phases[p]);
        end

        // Clip corner: 8000 and -8000 as the two oldest samples of a fresh window
`ifdef ECG_WIN_CLIP_EN
        clipHi = 4095;
        clipLo = -4096;
`else
        clipHi = 8000;
        clipLo = -8000;
`endif
        feedSample(8000);
        feedSample(-8000);
        for (int j = 2; j < WIN_SIZE; j++) begin
            feedSample(j);
        end
        @(negedge clk);
        idleInputs();
        checkOutput("clip x_valid", int'(xValid), 1);
        checkOutput("clip slot0", int'($signed(x[0 +: BITSIZE])), clipHi);
        checkOutput("clip slot1", int'($signed(x[BITSIZE +: BITSIZE])), clipLo);
        checkOutput("clip slot91", int'($signed(x[(WIN_SIZE-1)*BITSIZE +: BITSIZE])), WIN_SIZE - 1);

        // Asynchronous reset during HOLD clears outputs with no clock edge
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async rst x_valid", int'(xValid), 0);
        checkOutput("async rst s_ready", int'(sReady), 0);
        checkOutput("async rst win_cnt", int'(winCnt), 0);
        checkWindow("async rst x", expWin[0]);

        // Recovery after reset: ready again and a full window needed
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("recover s_ready", int'(sReady), 1);
        for (int j = 0; j < WIN_SIZE - 1; j++) begin
            feedSample(j);
        end
        @(negedge clk);
        idleInputs();
        checkOutput("recover 91 x_valid", int'(xValid), 0);
        feedSample(WIN_SIZE - 1);
        @(negedge clk);
        idleInputs();
        checkOutput("recover 92 x_valid", int'(xValid), 1);
        checkWindow("recover window", expWin[1]);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
